// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous SRAM between the fetch and data ports.
// Data wins conflicts; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic [3:0]        m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  owner_t      rd_owner_reg, rd_owner_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic [15:0] conflict_cnt_reg, conflict_cnt_next;
  logic        fetch_forced;
  logic        i_grant;
  logic        d_grant;

  // Grants are purely combinational so a granted access reaches the SRAM in the same cycle.
  always_comb begin
    fetch_forced = (starve_cnt_reg == LIMIT);
    i_grant      = rst_n && i_req && (!d_req || fetch_forced);
    d_grant      = rst_n && d_req && !(i_req && fetch_forced);
  end

  assign i_ready = i_grant;
  assign d_ready = d_grant;
  assign m_en    = i_grant || d_grant;
  assign m_wen   = d_grant ? d_we : 4'h0;
  assign m_addr  = i_grant ? i_addr : (d_grant ? d_addr : '0);
  assign m_wdata = d_grant ? d_wdata : '0;

  always_comb begin
    starve_cnt_next   = starve_cnt_reg;
    conflict_cnt_next = conflict_cnt_reg;
    rd_owner_next     = OWN_NONE;

    if (!i_req || i_grant) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt_reg < LIMIT) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    if (i_req && d_req && (conflict_cnt_reg != 16'hFFFF)) begin
      conflict_cnt_next = conflict_cnt_reg + 16'd1;
    end

    // Writes complete at the grant edge, so only reads leave a pending return.
    if (i_grant) begin
      rd_owner_next = OWN_I;
    end else if (d_grant && (d_we == 4'h0)) begin
      rd_owner_next = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner_reg     <= OWN_NONE;
      starve_cnt_reg   <= 4'd0;
      conflict_cnt_reg <= 16'd0;
    end else begin
      rd_owner_reg     <= rd_owner_next;
      starve_cnt_reg   <= starve_cnt_next;
      conflict_cnt_reg <= conflict_cnt_next;
    end
  end

  // Returns are masked while reset is held so an in-flight read never surfaces.
  assign i_rvalid     = rst_n && (rd_owner_reg == OWN_I) && !i_flush;
  assign d_rvalid     = rst_n && (rd_owner_reg == OWN_D);
  assign i_rdata      = i_rvalid ? m_rdata : '0;
  assign d_rdata      = d_rvalid ? m_rdata : '0;
  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a cycle-level behavioural model.
// An SRAM model in the bench answers the arbiter's memory port.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_flush = 1'b0;
  logic        i_ready, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic [3:0]  d_we = 4'h0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic [15:0] conflict_cnt;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Environment SRAM: registered read of the old word, byte-enabled write.
  logic [31:0] sram [0:1023];
  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= sram[m_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (m_wen[b]) sram[m_addr[11:2]][8*b +: 8] = m_wdata[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  int          losses;
  int          exp_conf;
  int          ret_kind;     // 0 none, 1 fetch, 2 data
  logic [31:0] ret_data;
  logic        last_i_grant, last_d_grant;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          verbose = 1'b1;

  logic [32:0] obs_i_ret, obs_d_ret;
  logic        obs_m_en;
  logic [15:0] obs_conf;
  logic [9:0]  grant_bits;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already stable; check at negedge, advance model, return after posedge.
  task automatic do_cycle();
    logic        exp_i, exp_d, exp_irv, exp_drv;
    logic [31:0] exp_addr;
    int          idx;
    @(negedge clk);
    exp_i    = rst_n && i_req && (!d_req || losses >= LIMIT);
    exp_d    = rst_n && d_req && !exp_i;
    exp_addr = exp_i ? i_addr : (exp_d ? d_addr : 32'h0);
    exp_irv  = rst_n && (ret_kind == 1) && !i_flush;
    exp_drv  = rst_n && (ret_kind == 2);

    check("ready", 64'({i_ready, d_ready}), 64'({exp_i, exp_d}));
    check("m_en_wen", 64'({m_en, m_wen}), 64'({exp_i | exp_d, (exp_d ? d_we : 4'h0)}));
    check("m_addr", 64'(m_addr), 64'(exp_addr));
    check("m_wdata", 64'(m_wdata), 64'(exp_d ? d_wdata : 32'h0));
    check("i_return", 64'({i_rvalid, i_rdata}), 64'({exp_irv, (exp_irv ? ret_data : 32'h0)}));
    check("d_return", 64'({d_rvalid, d_rdata}), 64'({exp_drv, (exp_drv ? ret_data : 32'h0)}));
    check("conflict_cnt", 64'(conflict_cnt), 64'(exp_conf));

    obs_i_ret  = {i_rvalid, i_rdata};
    obs_d_ret  = {d_rvalid, d_rdata};
    obs_m_en   = m_en;
    obs_conf   = conflict_cnt;
    grant_bits = {grant_bits[8:0], i_ready};

    if (verbose) begin
      if (exp_i) $display("t=%0t fetch grant addr 0x%08h", $time, i_addr);
      if (exp_d) $display("t=%0t data %s addr 0x%08h we %h wdata 0x%08h", $time,
                          (d_we == 4'h0) ? "read" : "write", d_addr, d_we, d_wdata);
      if (exp_irv || exp_drv) $display("t=%0t %s return 0x%08h", $time, exp_irv ? "fetch" : "data", ret_data);
    end

    last_i_grant = exp_i;
    last_d_grant = exp_d;
    if (!rst_n) begin
      losses   = 0;
      exp_conf = 0;
      ret_kind = 0;
    end else begin
      if (i_req && d_req && exp_conf < 65535) exp_conf++;
      idx      = int'(exp_addr[11:2]);
      ret_kind = exp_i ? 1 : ((exp_d && d_we == 4'h0) ? 2 : 0);
      ret_data = ref_mem[idx];
      if (exp_d)
        for (int b = 0; b < 4; b++)
          if (d_we[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
      if (i_req && !exp_i) losses = (losses < LIMIT) ? losses + 1 : LIMIT;
      else losses = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    losses = 0; exp_conf = 0; ret_kind = 0; ret_data = 32'h0; grant_bits = 10'h0;
    last_i_grant = 1'b0; last_d_grant = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = $urandom;
      sram[i]    = ref_mem[i];
    end
    ref_mem[0] = 32'h13;  sram[0] = 32'h13;
    ref_mem[1] = 32'h93;  sram[1] = 32'h93;
    ref_mem[2] = 32'h113; sram[2] = 32'h113;

    // Reset with both ports requesting: nothing may be granted.
    i_req = 1'b1; d_req = 1'b1;
    repeat (2) do_cycle();
    check("reset_m_en", 64'(obs_m_en), 64'(0));
    i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    do_cycle();
    check("reset_conf", 64'(obs_conf), 64'(0));

    // Fetch only: three back-to-back reads.
    i_req = 1'b1; i_addr = 32'h0; do_cycle();
    i_addr = 32'h4; do_cycle();
    check("fetch_ret0", 64'(obs_i_ret), 64'({1'b1, 32'h13}));
    i_addr = 32'h8; do_cycle();
    check("fetch_ret1", 64'(obs_i_ret), 64'({1'b1, 32'h93}));
    i_req = 1'b0; do_cycle();
    check("fetch_ret2", 64'(obs_i_ret), 64'({1'b1, 32'h113}));

    // Data write then read back.
    d_req = 1'b1; d_we = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; do_cycle();
    d_we = 4'h0; d_wdata = 32'h0; do_cycle();
    check("write_no_ret", 64'(obs_d_ret), 64'(0));
    d_req = 1'b0; do_cycle();
    check("readback", 64'(obs_d_ret), 64'({1'b1, 32'hDEADBEEF}));

    // Continuous conflict for ten cycles.
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
    repeat (10) do_cycle();
    check("conflict_pattern", 64'(grant_bits), 64'(10'b0000100001));
    i_req = 1'b0; d_req = 1'b0; do_cycle();
    check("conflict_cnt10", 64'(obs_conf), 64'(10));

    // Flush of a returning fetch while the next fetch is arbitrated.
    i_req = 1'b1; i_addr = 32'h20; do_cycle();
    i_addr = 32'h40; i_flush = 1'b1; do_cycle();
    check("flush_drop", 64'(obs_i_ret[32]), 64'(0));
    i_req = 1'b0; i_flush = 1'b0; do_cycle();
    check("after_flush", 64'(obs_i_ret), 64'({1'b1, ref_mem[16]}));

    // Reset arriving while a data read is in flight.
    d_req = 1'b1; d_addr = 32'h100; do_cycle();
    rst_n = 1'b0; i_req = 1'b1; do_cycle();
    check("reset_mid_read", 64'(obs_d_ret[32]), 64'(0));
    check("reset_mid_m_en", 64'(obs_m_en), 64'(0));
    i_req = 1'b0; d_req = 1'b0; rst_n = 1'b1; do_cycle();
    check("reset_conf_clear", 64'(obs_conf), 64'(0));

    // Randomised traffic; an ungranted requester keeps its request stable.
    for (int n = 0; n < 1500; n++) begin
      if (!i_req || last_i_grant) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = {20'h0, 10'($urandom), 2'b00};
      end
      if (!d_req || last_d_grant) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_addr  = {20'h0, 10'($urandom), 2'b00};
        d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        d_wdata = $urandom;
      end
      i_flush = ($urandom_range(0, 7) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      do_cycle();
    end
    i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0; rst_n = 1'b1; d_we = 4'h0;
    do_cycle();

    // Saturation of the conflict counter from a clean reset.
    verbose = 1'b0;
    rst_n = 1'b0; do_cycle();
    rst_n = 1'b1;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h14;
    repeat (65540) do_cycle();
    i_req = 1'b0; d_req = 1'b0; do_cycle();
    check("conflict_sat", 64'(obs_conf), 64'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
